// File: rtl/kbd_pkg.sv
// Shared constants and token encoding for the keypad token encoder.
// Holds the operator/command token codes, the command index offsets and the
// index-to-token function used by the encoder top.
package kbd_pkg;

  localparam logic [7:0] DIGIT_BASE = 8'h00;
  localparam logic [7:0] OP_ADD     = 8'hA0;
  localparam logic [7:0] OP_SUB     = 8'hA1;
  localparam logic [7:0] OP_MUL     = 8'hA2;
  localparam logic [7:0] OP_DIV     = 8'hA3;
  localparam logic [7:0] OP_LB      = 8'hA4;
  localparam logic [7:0] OP_RB      = 8'hA5;
  localparam logic [7:0] CMD_DEL    = 8'hB0;
  localparam logic [7:0] CMD_PTR_L  = 8'hB1;
  localparam logic [7:0] CMD_PTR_R  = 8'hB2;
  localparam logic [7:0] CMD_EVAL   = 8'hB3;
  localparam logic [7:0] EXTRA_BASE = 8'hC0;

  // Offsets of each command within the cmd input vector.
  localparam int unsigned CMD_DEL_OFS   = 0;
  localparam int unsigned CMD_PTR_L_OFS = 1;
  localparam int unsigned CMD_PTR_R_OFS = 2;
  localparam int unsigned CMD_EVAL_OFS  = 3;

  localparam int unsigned NUM_DIGITS   = 10;
  localparam int unsigned STD_BUTTONS  = 16;
  localparam int unsigned NUM_STD_CMDS = 4;

  // Token for input index idx; buttons is the number of key inputs, so
  // idx >= buttons addresses the command inputs. Caller truncates to WIDTH.
  function automatic logic [31:0] code_of(input int unsigned idx, input int unsigned buttons);
    int unsigned j;
    j = 0;
    if (idx < buttons) begin
      if (idx < NUM_DIGITS) return 32'(DIGIT_BASE) + 32'(idx);
      if (idx < STD_BUTTONS) return 32'(OP_ADD) + 32'(idx - NUM_DIGITS);
    end else begin
      j = idx - buttons;
      if (j < NUM_STD_CMDS) return 32'(CMD_DEL) + 32'(j);
    end
    return 32'(EXTRA_BASE) + 32'(idx - STD_BUTTONS);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-input synchroniser and debouncer.
// Ports: clk_i clock, rst_ni async active-low reset, raw_i asynchronous level,
// held_o debounced level (flips after DEBOUNCE_CYCLES consecutive disagreeing
// synced samples).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic held_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            held_q, held_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    held_d = held_q;
    if (sync2_q != held_q) begin
      // This cycle completes the run of disagreeing samples: accept the level.
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        held_d = ~held_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_o = held_q;

endmodule

// File: rtl/keypad_token_encoder.sv
// Keypad front-end: debounces every key/command input, turns each press (and
// optional auto-repeat) into one token and queues it in a small FIFO.
// Ports: clock, reset_n (async active-low), b/cmd raw levels, tok_data/
// tok_valid/tok_ready token stream, overflow sticky lost-event flag,
// held debounced levels.
module keypad_token_encoder
  import kbd_pkg::*;
#(
  parameter int unsigned                  WIDTH           = 8,
  parameter int unsigned                  BUTTONS         = 16,
  parameter int unsigned                  CMDS            = 4,
  parameter int unsigned                  DEBOUNCE_CYCLES = 4,
  parameter int unsigned                  REPEAT_DELAY    = 0,
  parameter int unsigned                  REPEAT_RATE     = 1,
  parameter logic [BUTTONS+CMDS-1:0]      REPEAT_MASK     = '0,
  parameter int unsigned                  FIFO_DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [BUTTONS-1:0]      b,
  input  logic [CMDS-1:0]         cmd,
  output logic [WIDTH-1:0]        tok_data,
  output logic                    tok_valid,
  input  logic                    tok_ready,
  output logic                    overflow,
  output logic [BUTTONS+CMDS-1:0] held
);

  localparam int unsigned N      = BUTTONS + CMDS;
  localparam int unsigned IdxW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TmrW   = $clog2(RptMax + 1);
  localparam bit          RptEn  = (REPEAT_DELAY != 0);
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(FIFO_DEPTH);

  logic [N-1:0] raw;
  assign raw = {cmd, b};

  for (genvar gi = 0; gi < N; gi++) begin : g_db
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (clock),
      .rst_ni(reset_n),
      .raw_i (raw[gi]),
      .held_o(held[gi])
    );
  end

  logic [N-1:0]      held_prev_q;
  logic [N-1:0]      pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic [IdxW-1:0]   last_key_q, last_key_d;
  logic              rpt_active_q, rpt_active_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;

  logic [N-1:0]      rise, elig, ev, clr, drop;
  logic              fire, push, pop, full;
  logic [IdxW-1:0]   sel;
  logic [31:0]       code_full;
  logic [WIDTH-1:0]  wdata;

  // Auto-repeat timer. The timer holds "cycles left minus one", so a repeat
  // lands REPEAT_DELAY cycles after the press and REPEAT_RATE after that.
  always_comb begin
    rise         = held & ~held_prev_q;
    elig         = rise & REPEAT_MASK;
    fire         = 1'b0;
    last_key_d   = last_key_q;
    rpt_active_d = rpt_active_q;
    timer_d      = timer_q;
    if (RptEn) begin
      if (|elig) begin
        rpt_active_d = 1'b1;
        timer_d      = TmrW'(REPEAT_DELAY - 1);
        for (int i = N - 1; i >= 0; i--) begin
          if (elig[i]) last_key_d = IdxW'(i);
        end
      end else if (rpt_active_q) begin
        if (!held[last_key_q]) begin
          rpt_active_d = 1'b0;
        end else if (timer_q == '0) begin
          fire    = 1'b1;
          timer_d = TmrW'(REPEAT_RATE - 1);
        end else begin
          timer_d = timer_q - TmrW'(1);
        end
      end
    end
  end

  // Event collection, lowest-index enqueue and overflow detection.
  always_comb begin
    ev = rise;
    if (fire) ev[last_key_q] = 1'b1;

    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = IdxW'(i);
    end

    full = (count_q == DepthC);
    pop  = tok_valid && tok_ready;
    push = (|pending_q) && (!full || pop);

    clr = '0;
    if (push) clr[sel] = 1'b1;

    // An event colliding with a still-pending copy is lost, unless that copy
    // leaves for the FIFO this very cycle.
    drop       = ev & pending_q & ~clr;
    pending_d  = (pending_q & ~clr) | ev;
    overflow_d = overflow_q | (|drop);

    code_full = code_of(32'(sel), BUTTONS);
    wdata     = code_full[WIDTH-1:0];

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_prev_q  <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      last_key_q   <= '0;
      rpt_active_q <= 1'b0;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      held_prev_q  <= held;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      last_key_q   <= last_key_d;
      rpt_active_q <= rpt_active_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: the output is gated by occupancy.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign tok_valid = (count_q != '0);
  assign tok_data  = tok_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_token_encoder.sv
// Directed bench for keypad_token_encoder: token scoreboard on every handshake,
// stall-stability checks, and literal latency/count/spacing expectations.
module tb_keypad_token_encoder;

  localparam int NB = 16;
  localparam int NC = 4;
  localparam int NI = NB + NC;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NB-1:0] b;
  logic [NC-1:0] cmd;
  logic [7:0]    tok_data;
  logic          tok_valid;
  logic          tok_ready;
  logic          overflow;
  logic [NI-1:0] held;

  keypad_token_encoder #(
    .WIDTH          (8),
    .BUTTONS        (NB),
    .CMDS           (NC),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .REPEAT_MASK    (20'h2_0000),
    .FIFO_DEPTH     (4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .b        (b),
    .cmd      (cmd),
    .tok_data (tok_data),
    .tok_valid(tok_valid),
    .tok_ready(tok_ready),
    .overflow (overflow),
    .held     (held)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         hs_times[$];
  int         hs_count = 0;
  bit         sb_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  logic [7:0] code_tab [NI] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                8'h08, 8'h09, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
                                8'hB0, 8'hB1, 8'hB2, 8'hB3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_in(input int i, input logic v);
    if (i < NB) b[i] = v;
    else cmd[i-NB] = v;
  endtask

  task automatic expect_tok(input int i);
    exp_q.push_back(code_tab[i]);
  endtask

  // Edges from e0 until tok_valid is first seen high (bounded).
  task automatic measure_rise(input int e0, input int want, input string name);
    int got = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock);
      #1;
      if (tok_valid) begin
        got = cyc - e0;
        break;
      end
    end
    #1;
    chk(name, 32'(got), 32'(want));
  endtask

  task automatic tap(input int i);
    expect_tok(i);
    set_in(i, 1'b1);
    wait_edges(8);
    set_in(i, 1'b0);
    wait_edges(8);
  endtask

  // Scoreboard: every accepted token must be the next expected one.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && sb_en) begin
        if (prev_stall) begin
          chk("stall_valid", 32'(tok_valid), 32'd1);
          chk("stall_data", 32'(tok_data), 32'(prev_data));
        end
        if (tok_valid && tok_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_token: got 0x%0h, want none", tok_data);
          end else begin
            chk("token", 32'(tok_data), 32'(exp_q.pop_front()));
          end
          hs_count++;
          hs_times.push_back(cyc);
        end
        prev_stall = tok_valid && !tok_ready;
        prev_data  = tok_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  int h0;
  int e0;
  int base;
  int idx4[6] = '{0, 1, 2, 8, 9, 10};

  initial begin
    reset_n   = 1'b0;
    b         = '0;
    cmd       = '0;
    tok_ready = 1'b1;
    wait_edges(3);
    chk("rst_valid", 32'(tok_valid), 32'd0);
    chk("rst_data", 32'(tok_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_held", 32'(held), 32'd0);
    reset_n = 1'b1;
    sb_en   = 1'b1;
    wait_edges(5);

    // Single press: latency, held level, exactly one token.
    h0 = hs_count;
    expect_tok(7);
    e0 = cyc;
    set_in(7, 1'b1);
    measure_rise(e0, 8, "b7_latency");
    wait_edges(10);
    chk("b7_held", 32'(held), 32'h80);
    set_in(7, 1'b0);
    wait_edges(20);
    chk("b7_count", 32'(hs_count - h0), 32'd1);
    chk("b7_released", 32'(held), 32'd0);

    // Bounce then stable hold.
    h0 = hs_count;
    for (int n = 0; n < 10; n++) begin
      set_in(3, 1'b1);
      wait_edges(1);
      set_in(3, 1'b0);
      wait_edges(1);
    end
    wait_edges(10);
    chk("b3_bounce_silent", 32'(hs_count - h0), 32'd0);
    expect_tok(3);
    set_in(3, 1'b1);
    wait_edges(15);
    chk("b3_hold_count", 32'(hs_count - h0), 32'd1);
    set_in(3, 1'b0);
    wait_edges(10);

    // Simultaneous presses come out in index order on consecutive cycles.
    h0 = hs_count;
    expect_tok(12);
    expect_tok(19);
    set_in(19, 1'b1);
    set_in(12, 1'b1);
    wait_edges(15);
    chk("simul_count", 32'(hs_count - h0), 32'd2);
    chk("simul_gap", 32'(hs_times[hs_times.size()-1] - hs_times[hs_times.size()-2]), 32'd1);
    set_in(19, 1'b0);
    set_in(12, 1'b0);
    wait_edges(10);

    // Six presses against a stalled 4-deep FIFO.
    tok_ready = 1'b0;
    for (int n = 0; n < 6; n++) tap(idx4[n]);
    chk("bp_valid", 32'(tok_valid), 32'd1);
    chk("bp_head", 32'(tok_data), 32'h00);
    chk("bp_overflow", 32'(overflow), 32'd0);
    h0 = hs_count;
    tok_ready = 1'b1;
    wait_edges(15);
    chk("bp_drain_count", 32'(hs_count - h0), 32'd6);
    chk("bp_overflow_after", 32'(overflow), 32'd0);

    // Re-press of a key whose event is still pending is lost.
    tok_ready = 1'b0;
    for (int n = 0; n < 4; n++) tap(n);
    tap(5);
    chk("ovf_before", 32'(overflow), 32'd0);
    set_in(5, 1'b1);
    wait_edges(8);
    set_in(5, 1'b0);
    wait_edges(8);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(tok_data), 32'h00);
    h0 = hs_count;
    tok_ready = 1'b1;
    wait_edges(15);
    chk("ovf_drain_count", 32'(hs_count - h0), 32'd5);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Auto-repeat on ptrLeft: held 30 cycles gives press + 7 repeats.
    h0 = hs_count;
    for (int n = 0; n < 8; n++) expect_tok(17);
    set_in(17, 1'b1);
    wait_edges(30);
    set_in(17, 1'b0);
    wait_edges(30);
    chk("rpt_count", 32'(hs_count - h0), 32'd8);
    base = hs_times.size() - 8;
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("rpt_gap%0d", k), 32'(hs_times[base+k] - hs_times[base+k-1]),
          (k == 1) ? 32'(RD) : 32'(RR));
    end

    // Reset during a repeating hold.
    sb_en = 1'b0;
    set_in(17, 1'b1);
    wait_edges(20);
    tok_ready = 1'b0;
    wait_edges(12);
    chk("pre_reset_valid", 32'(tok_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tok_valid), 32'd0);
    chk("mid_rst_data", 32'(tok_data), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_held", 32'(held), 32'd0);
    wait_edges(3);
    reset_n = 1'b1;
    e0 = cyc;
    measure_rise(e0, 8, "post_reset_latency");
    chk("post_reset_token", 32'(tok_data), 32'hB1);
    set_in(17, 1'b0);
    tok_ready = 1'b1;
    wait_edges(40);
    chk("final_drained", 32'(tok_valid), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
